// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the RV32 load/store memory stage: funct3 codes,
// FSM state encoding and the store byte-enable helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [3:0] wmask_of(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B:    wmask_of = 4'b0001 << off;
            F3_H:    wmask_of = 4'b0011 << off;
            F3_W:    wmask_of = 4'b1111;
            default: wmask_of = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request, response and data-RAM signals of the load/store stage.
// The stage itself connects through the slave modport.
interface lsu_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_is_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misaligned;

    logic            mem_valid;
    logic            mem_write_en;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
        output mem_valid, mem_write_en, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
        input  mem_valid, mem_write_en, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_stage_load_ext.sv
// Load data alignment: selects the addressed byte/half lane of the RAM word
// and sign- or zero-extends it according to funct3.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_data
);
    logic [4:0]  w_bidx;
    logic [4:0]  w_hidx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_bidx = {i_off, 3'b000};
        w_hidx = {i_off[1], 4'b0000};
        w_byte = i_word[w_bidx +: 8];
        w_half = i_word[w_hidx +: 16];
        case (i_funct3)
            F3_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
            F3_W:    o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32 load/store stage in front of the data RAM: one op at a time,
// IDLE -> ACCESS -> RESP, or IDLE -> RESP for rejected ops.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input logic            clock,
    input logic            reset,
    lsu_mem_stage_if.slave bus
);
    state_t          r_state, w_state_nxt;
    logic            r_req_ready, w_req_ready_nxt;
    logic            r_is_store, w_is_store_nxt;
    logic [2:0]      r_funct3, w_funct3_nxt;
    logic [1:0]      r_off, w_off_nxt;
    logic            r_resp_valid, w_resp_valid_nxt;
    logic            r_resp_mis, w_resp_mis_nxt;
    logic            r_first, w_first_nxt;
    logic [XLEN-1:0] r_hold, w_hold_nxt;
    logic            r_mem_valid, w_mem_valid_nxt;
    logic            r_mem_we, w_mem_we_nxt;
    logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]      r_mem_wmask, w_mem_wmask_nxt;

    logic            w_size_h, w_size_w, w_illegal, w_misaligned;
    logic [1:0]      w_off;
    logic [XLEN-1:0] w_ext, w_load_data;

    always_comb begin
        w_size_h = (bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU);
        w_size_w = (bus.req_funct3 == F3_W);
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: w_illegal = 1'b0;
            F3_BU, F3_HU:     w_illegal = bus.req_is_store;
            default:          w_illegal = 1'b1;
        endcase
        w_misaligned = CHECK_ALIGN && ((w_size_h && bus.req_addr[0]) ||
                                       (w_size_w && (bus.req_addr[1:0] != 2'b00)));
        // Without alignment checking the sub-size address bits are simply dropped.
        if (w_size_w)      w_off = 2'b00;
        else if (w_size_h) w_off = {bus.req_addr[1], 1'b0};
        else               w_off = bus.req_addr[1:0];
    end

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_word   (bus.mem_rdata),
        .o_data   (w_ext)
    );

    assign w_load_data = r_is_store ? '0 : w_ext;

    always_comb begin
        w_state_nxt     = r_state;
        w_is_store_nxt  = r_is_store;
        w_funct3_nxt    = r_funct3;
        w_off_nxt       = r_off;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_mis_nxt  = r_resp_mis;
        w_first_nxt     = 1'b0;
        w_hold_nxt      = r_hold;
        w_mem_valid_nxt = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        w_mem_wmask_nxt = '0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_is_store_nxt = bus.req_is_store;
                    w_funct3_nxt   = bus.req_funct3;
                    w_off_nxt      = w_off;
                    if (w_misaligned || w_illegal) begin
                        w_state_nxt      = RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_mis_nxt   = 1'b1;
                        w_hold_nxt       = '0;
                    end else begin
                        w_state_nxt     = ACCESS;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_we_nxt    = bus.req_is_store;
                        w_mem_addr_nxt  = {bus.req_addr[XLEN-1:2], 2'b00};
                        if (bus.req_is_store) begin
                            w_mem_wmask_nxt = wmask_of(bus.req_funct3, w_off);
                            case (bus.req_funct3)
                                F3_B:    w_mem_wdata_nxt = {4{bus.req_wdata[7:0]}};
                                F3_H:    w_mem_wdata_nxt = {2{bus.req_wdata[15:0]}};
                                default: w_mem_wdata_nxt = bus.req_wdata;
                            endcase
                        end
                    end
                end
            end
            ACCESS: begin
                w_state_nxt      = RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_mis_nxt   = 1'b0;
                w_first_nxt      = 1'b1;
                w_hold_nxt       = '0;
            end
            RESP: begin
                // RAM data is only valid in the first RESP cycle; keep it afterwards.
                if (r_first) w_hold_nxt = w_load_data;
                if (bus.resp_ready) begin
                    w_state_nxt      = IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_resp_mis_nxt   = 1'b0;
                    w_hold_nxt       = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_req_ready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_resp_valid <= 1'b0;
            r_resp_mis   <= 1'b0;
            r_first      <= 1'b0;
            r_hold       <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_is_store   <= w_is_store_nxt;
            r_funct3     <= w_funct3_nxt;
            r_off        <= w_off_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_mis   <= w_resp_mis_nxt;
            r_first      <= w_first_nxt;
            r_hold       <= w_hold_nxt;
            r_mem_valid  <= w_mem_valid_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wmask  <= w_mem_wmask_nxt;
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_first ? w_load_data : r_hold;
    assign bus.resp_misaligned = r_resp_mis;
    assign bus.mem_valid       = r_mem_valid;
    assign bus.mem_write_en    = r_mem_we;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_wmask       = r_mem_wmask;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: two instances (alignment checked / ignored) share
// one behavioural RAM; ops come from a vector table, responses via a queue.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    typedef struct {
        bit          sel;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          acc;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        bit          mis;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          mis;
    } exp_t;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    logic        t_sel, t_req_valid, t_is_store, t_resp_ready;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] ram [0:255];
    logic [31:0] ram_rdata;

    lsu_mem_stage_if #(.XLEN(32)) b0 ();
    lsu_mem_stage_if #(.XLEN(32)) b1 ();

    lsu_mem_stage #(.XLEN(32), .CHECK_ALIGN(1'b1)) u_dut0 (.clock(clock), .reset(reset), .bus(b0));
    lsu_mem_stage #(.XLEN(32), .CHECK_ALIGN(1'b0)) u_dut1 (.clock(clock), .reset(reset), .bus(b1));

    assign b0.req_valid    = t_req_valid & ~t_sel;
    assign b1.req_valid    = t_req_valid & t_sel;
    assign b0.req_is_store = t_is_store;
    assign b1.req_is_store = t_is_store;
    assign b0.req_funct3   = t_f3;
    assign b1.req_funct3   = t_f3;
    assign b0.req_addr     = t_addr;
    assign b1.req_addr     = t_addr;
    assign b0.req_wdata    = t_wdata;
    assign b1.req_wdata    = t_wdata;
    assign b0.resp_ready   = t_resp_ready;
    assign b1.resp_ready   = t_resp_ready;
    assign b0.mem_rdata    = ram_rdata;
    assign b1.mem_rdata    = ram_rdata;

    logic        o_req_ready, o_resp_valid, o_mis, o_mem_valid, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    assign o_req_ready  = t_sel ? b1.req_ready       : b0.req_ready;
    assign o_resp_valid = t_sel ? b1.resp_valid      : b0.resp_valid;
    assign o_rdata      = t_sel ? b1.resp_rdata      : b0.resp_rdata;
    assign o_mis        = t_sel ? b1.resp_misaligned : b0.resp_misaligned;
    assign o_mem_valid  = t_sel ? b1.mem_valid       : b0.mem_valid;
    assign o_mem_we     = t_sel ? b1.mem_write_en    : b0.mem_write_en;
    assign o_mem_addr   = t_sel ? b1.mem_addr        : b0.mem_addr;
    assign o_mem_wdata  = t_sel ? b1.mem_wdata       : b0.mem_wdata;
    assign o_mem_wmask  = t_sel ? b1.mem_wmask       : b0.mem_wmask;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word RAM: registers read data on a request edge, sentinel otherwise.
    always @(posedge clock) begin
        if (o_mem_valid) begin
            if (o_mem_we)
                for (int i = 0; i < 4; i++)
                    if (o_mem_wmask[i]) ram[o_mem_addr[9:2]][8*i +: 8] <= o_mem_wdata[8*i +: 8];
            ram_rdata <= ram[o_mem_addr[9:2]];
        end else begin
            ram_rdata <= 32'h8000_0000;
        end
    end

    task automatic chk_b(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic chk_w(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit sel, input bit st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit acc, input logic [3:0] mask,
                                input logic [31:0] mwdata, input logic [31:0] rdata,
                                input bit mis, input int hold);
        vec_t v;
        v.sel = sel; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.acc = acc; v.mask = mask; v.mwdata = mwdata; v.rdata = rdata;
        v.mis = mis; v.hold = hold;
        return v;
    endfunction

    task automatic check_idle_zero(input string n);
        chk_b({n, " req_ready"}, o_req_ready, 1'b0);
        chk_b({n, " resp_valid"}, o_resp_valid, 1'b0);
        chk_w({n, " resp_rdata"}, o_rdata, 32'h0);
        chk_b({n, " misaligned"}, o_mis, 1'b0);
        chk_b({n, " mem_valid"}, o_mem_valid, 1'b0);
        chk_b({n, " mem_write_en"}, o_mem_we, 1'b0);
        chk_w({n, " mem_addr"}, o_mem_addr, 32'h0);
        chk_w({n, " mem_wdata"}, o_mem_wdata, 32'h0);
        chk_w({n, " mem_wmask"}, {28'h0, o_mem_wmask}, 32'h0);
    endtask

    task automatic run_op(input int k);
        vec_t v;
        exp_t e;
        int lat;
        int nmv;
        string n;
        v = vecs[k];
        n = $sformatf("v%0d", k);
        t_sel = v.sel;
        @(negedge clock);
        chk_b({n, " req_ready before"}, o_req_ready, 1'b1);
        t_req_valid = 1'b1; t_is_store = v.st; t_f3 = v.f3;
        t_addr = v.addr; t_wdata = v.wdata;
        t_resp_ready = (v.hold == 0);
        sb_q.push_back('{rdata: v.rdata, mis: v.mis});
        lat = 0;
        nmv = 0;
        do begin
            @(negedge clock);
            lat++;
            t_req_valid = 1'b0;
            if (o_mem_valid) begin
                nmv++;
                chk_w({n, " mem_addr"}, o_mem_addr, v.addr & 32'hFFFF_FFFC);
                chk_b({n, " mem_write_en"}, o_mem_we, v.st);
                chk_w({n, " mem_wmask"}, {28'h0, o_mem_wmask}, {28'h0, v.mask});
                if (v.st) chk_w({n, " mem_wdata"}, o_mem_wdata, v.mwdata);
                chk_b({n, " req_ready in access"}, o_req_ready, 1'b0);
            end
        end while (!o_resp_valid && lat < 6);
        chk_w({n, " resp latency"}, lat, v.acc ? 2 : 1);
        chk_w({n, " mem requests"}, nmv, v.acc ? 1 : 0);
        for (int h = 0; h < v.hold; h++) begin
            if (h > 0) @(negedge clock);
            chk_b($sformatf("%s hold%0d resp_valid", n, h), o_resp_valid, 1'b1);
            chk_w($sformatf("%s hold%0d resp_rdata", n, h), o_rdata, v.rdata);
            chk_b($sformatf("%s hold%0d req_ready", n, h), o_req_ready, 1'b0);
        end
        t_resp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            chk_b({n, " scoreboard entry"}, 1'b0, 1'b1);
        end else begin
            e = sb_q.pop_front();
            chk_w({n, " resp_rdata"}, o_rdata, e.rdata);
            chk_b({n, " resp_misaligned"}, o_mis, e.mis);
        end
        @(negedge clock);
        chk_b({n, " resp_valid after"}, o_resp_valid, 1'b0);
        chk_b({n, " req_ready after"}, o_req_ready, 1'b1);
    endtask

    // Reset pulse during ACCESS (store) or RESP (load): op is dropped silently.
    task automatic reset_mid(input bit in_resp);
        bit seen;
        string n;
        n = in_resp ? "rst_resp" : "rst_access";
        t_sel = 1'b0;
        @(negedge clock);
        t_req_valid = 1'b1;
        t_is_store = !in_resp;
        t_f3 = in_resp ? F3_BU : F3_W;
        t_addr = in_resp ? 32'h8000_0108 : 32'h8000_0110;
        t_wdata = 32'h5A5A_1234;
        t_resp_ready = 1'b0;
        @(negedge clock);
        t_req_valid = 1'b0;
        chk_b({n, " mem_valid"}, o_mem_valid, 1'b1);
        if (in_resp) begin
            @(negedge clock);
            chk_b({n, " resp_valid pending"}, o_resp_valid, 1'b1);
        end
        reset = 1'b0;
        @(negedge clock);
        check_idle_zero(n);
        reset = 1'b1;
        t_resp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (o_resp_valid) seen = 1'b1;
        end
        chk_b({n, " no response"}, seen, 1'b0);
        chk_b({n, " req_ready"}, o_req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs.push_back(mk(0, 1, F3_W,  32'h8000_0104, 32'hDEAD_BEEF, 1, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, F3_W,  32'h8000_0100, 32'h0011_2233, 1, 4'hF, 32'h0011_2233, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, F3_B,  32'h8000_0103, 32'h0000_00A5, 1, 4'h8, 32'hA5A5_A5A5, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, F3_W,  32'h8000_0100, 32'h0, 1, 4'h0, 32'h0, 32'hA511_2233, 0, 0));
        vecs.push_back(mk(0, 1, F3_W,  32'h8000_0108, 32'h80FF_7F01, 1, 4'hF, 32'h80FF_7F01, 32'h0, 0, 2));
        vecs.push_back(mk(0, 0, F3_B,  32'h8000_010A, 32'h0, 1, 4'h0, 32'h0, 32'hFFFF_FFFF, 0, 5));
        vecs.push_back(mk(0, 0, F3_BU, 32'h8000_010A, 32'h0, 1, 4'h0, 32'h0, 32'h0000_00FF, 0, 0));
        vecs.push_back(mk(0, 0, F3_H,  32'h8000_010A, 32'h0, 1, 4'h0, 32'h0, 32'hFFFF_80FF, 0, 0));
        vecs.push_back(mk(0, 0, F3_HU, 32'h8000_0108, 32'h0, 1, 4'h0, 32'h0, 32'h0000_7F01, 0, 0));
        vecs.push_back(mk(0, 0, F3_W,  32'h8000_0102, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 3));
        vecs.push_back(mk(0, 1, F3_H,  32'h8000_0106, 32'h1234_CAFE, 1, 4'hC, 32'hCAFE_CAFE, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, F3_W,  32'h8000_0104, 32'h0, 1, 4'h0, 32'h0, 32'hCAFE_BEEF, 0, 0));
        vecs.push_back(mk(0, 0, F3_H,  32'h8000_0101, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 1, F3_BU, 32'h8000_0100, 32'hFFFF_FFFF, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b011, 32'h8000_0100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 0, 3'b110, 32'h8000_0100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 0, F3_B,  32'h8000_0107, 32'h0, 1, 4'h0, 32'h0, 32'hFFFF_FFCA, 0, 0));
        vecs.push_back(mk(0, 0, F3_HU, 32'h8000_0106, 32'h0, 1, 4'h0, 32'h0, 32'h0000_CAFE, 0, 0));
        vecs.push_back(mk(0, 0, F3_BU, 32'h8000_0105, 32'h0, 1, 4'h0, 32'h0, 32'h0000_00BE, 0, 0));
        vecs.push_back(mk(1, 0, F3_W,  32'h8000_0102, 32'h0, 1, 4'h0, 32'h0, 32'hA511_2233, 0, 0));
        vecs.push_back(mk(1, 0, F3_H,  32'h8000_0103, 32'h0, 1, 4'h0, 32'h0, 32'hFFFF_A511, 0, 0));
        vecs.push_back(mk(1, 1, F3_H,  32'h8000_0105, 32'h0000_7777, 1, 4'h3, 32'h7777_7777, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, F3_W,  32'h8000_0104, 32'h0, 1, 4'h0, 32'h0, 32'hCAFE_7777, 0, 0));
        vecs.push_back(mk(0, 0, F3_W,  32'h8000_0110, 32'h0, 1, 4'h0, 32'h0, 32'h5A5A_1234, 0, 0));

        reset = 1'b0;
        t_sel = 1'b0; t_req_valid = 1'b0; t_is_store = 1'b0; t_resp_ready = 1'b1;
        t_f3 = 3'b000; t_addr = 32'h0; t_wdata = 32'h0;
        repeat (3) @(negedge clock);
        check_idle_zero("reset");
        reset = 1'b1;
        @(negedge clock);
        chk_b("reset release req_ready", o_req_ready, 1'b1);

        for (int k = 0; k < vecs.size() - 1; k++) run_op(k);
        reset_mid(1'b0);
        reset_mid(1'b1);
        run_op(vecs.size() - 1);
        chk_w("scoreboard drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
